// File: rtl/knn_acc_pkg.sv
// Shared widths, FSM state encoding and stream-entry layout for the KNN
// accelerator cache read path.
package knn_acc_pkg;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 9;
   localparam int DIM_W  = 8;
   localparam int NVEC_W = 9;
   localparam int TOT_W  = DIM_W + NVEC_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } stream_state_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              sop;
      logic              eop;
   } stream_entry_t;
endpackage

// File: rtl/knn_skid_fifo2.sv
// Two-entry FIFO that absorbs the cache read latency and downstream stalls.
// A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
module knn_skid_fifo2
   import knn_acc_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              push_sop,
   input  logic              push_eop,
   input  logic              pop,
   output logic [DATA_W-1:0] head_data,
   output logic              head_sop,
   output logic              head_eop,
   output logic [1:0]        occupancy
);
   stream_entry_t mem [2];
   logic          wr_ptr;
   logic          rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_pop  = pop && (occupancy != 2'd0);
   assign do_push = push && ((occupancy != 2'd2) || do_pop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem[0]    <= '0;
         mem[1]    <= '0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         occupancy <= 2'd0;
      end else if (flush) begin
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         occupancy <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= '{data: push_data, sop: push_sop, eop: push_eop};
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop)
            rd_ptr <= ~rd_ptr;
         occupancy <= occupancy + 2'(do_push) - 2'(do_pop);
      end
   end

   assign head_data = mem[rd_ptr].data;
   assign head_sop  = mem[rd_ptr].sop;
   assign head_eop  = mem[rd_ptr].eop;
endmodule

// File: rtl/knn_cache_streamer.sv
// Streams dim*nvec words from cache port 2 starting at base, tagged with sop/eop.
// Define KNN_STREAM_WRAP_EN to let a run wrap past the top of the cache instead of being rejected.
module knn_cache_streamer
   import knn_acc_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] base,
   input  logic [DIM_W-1:0]  dim,
   input  logic [NVEC_W-1:0] nvec,
   output logic [ADDR_W-1:0] cache_address,
   output logic              cache_chipselect,
   output logic              cache_clken,
   output logic              cache_write,
   output logic [3:0]        cache_byteenable,
   input  logic [DATA_W-1:0] cache_readdata,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_sop,
   output logic              out_eop,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        dbg_state
);
   stream_state_t     state;
   logic [DIM_W-1:0]  dim_q;
   logic [DIM_W-1:0]  word_in_vec;
   logic [NVEC_W-1:0] nvec_q;
   logic [NVEC_W-1:0] vec_idx;
   logic              inflight;
   logic              inflight_sop;
   logic              inflight_eop;
   logic [1:0]        occupancy;
   logic [2:0]        level;
   logic              pop;
   logic              issue;
   logic              cur_sop;
   logic              cur_eop;
   logic              last_word;
   logic              zero_run;
   logic              too_long;
   logic              head_sop;
   logic              head_eop;

   assign cache_clken      = 1'b1;
   assign cache_write      = 1'b0;
   assign cache_byteenable = 4'hF;
   assign dbg_state        = state;

   // Stream handshake: a word moves on every cycle with out_valid && out_ready; out_valid holds
   // until that happens (abort/reset excepted). A read is issued only when its return has a slot.
   assign pop              = out_valid && out_ready;
   assign level            = 3'(occupancy) + 3'(inflight);
   assign issue            = (state == RUN) && !abort && (level < (3'd2 + 3'(pop)));
   assign cache_chipselect = issue;

   assign cur_sop   = (word_in_vec == '0);
   assign cur_eop   = (word_in_vec == (dim_q - DIM_W'(1)));
   assign last_word = cur_eop && (vec_idx == (nvec_q - NVEC_W'(1)));
   assign zero_run  = (dim == '0) || (nvec == '0);

`ifdef KNN_STREAM_WRAP_EN
   assign too_long = 1'b0;
`else
   logic [TOT_W:0] run_end;
   assign run_end  = (TOT_W+1)'(base) + ((TOT_W+1)'(dim) * (TOT_W+1)'(nvec));
   assign too_long = run_end > (TOT_W+1)'(2**ADDR_W);
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         cache_address <= '0;
         dim_q         <= '0;
         nvec_q        <= '0;
         word_in_vec   <= '0;
         vec_idx       <= '0;
         inflight      <= 1'b0;
         inflight_sop  <= 1'b0;
         inflight_eop  <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
      end else begin
         done         <= 1'b0;
         err          <= 1'b0;
         inflight     <= issue;
         inflight_sop <= cur_sop;
         inflight_eop <= cur_eop;
         if (abort) begin
            state         <= IDLE;
            busy          <= 1'b0;
            cache_address <= '0;
            word_in_vec   <= '0;
            vec_idx       <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     if (zero_run) begin
                        done <= 1'b1;
                     end else if (too_long) begin
                        err <= 1'b1;
                     end else begin
                        state         <= RUN;
                        busy          <= 1'b1;
                        cache_address <= base;
                        dim_q         <= dim;
                        nvec_q        <= nvec;
                        word_in_vec   <= '0;
                        vec_idx       <= '0;
                     end
                  end
               end
               RUN: begin
                  if (issue) begin
                     cache_address <= cache_address + ADDR_W'(1);
                     if (cur_eop) begin
                        word_in_vec <= '0;
                        vec_idx     <= vec_idx + NVEC_W'(1);
                     end else begin
                        word_in_vec <= word_in_vec + DIM_W'(1);
                     end
                     if (last_word)
                        state <= DRAIN;
                  end
               end
               DRAIN: begin
                  // Finish only once the last returned word has been taken downstream.
                  if ((occupancy == 2'd0) && !inflight) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   knn_skid_fifo2 u_skid (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (abort),
      .push      (inflight),
      .push_data (cache_readdata),
      .push_sop  (inflight_sop),
      .push_eop  (inflight_eop),
      .pop       (pop),
      .head_data (out_data),
      .head_sop  (head_sop),
      .head_eop  (head_eop),
      .occupancy (occupancy)
   );

   assign out_valid = (occupancy != 2'd0);
   assign out_sop   = out_valid && head_sop;
   assign out_eop   = out_valid && head_eop;
endmodule

// File: doc/knn_cache_streamer.md
# knn_cache_streamer

Read-side sequencer for the 512×32 dual-port cache in the KNN accelerator. Drives the cache's second port (address2/chipselect2/clken2, read-only) to fetch a programmed run of feature vectors and presents them as a valid/ready word stream with start- and end-of-vector markers to the distance-computation datapath. Absorbs the cache's one-cycle read latency and downstream backpressure with a 2-entry skid buffer, so no word is dropped or duplicated.

## Interface
- DATA_W, 32: cache and stream word width.
- ADDR_W, 9: cache address width; depth = 2**ADDR_W.
- DIM_W, 8: width of words-per-vector field.
- NVEC_W, 9: width of vector-count field.
- clk  in  1  single clock; shared with the cache port-2 clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; latches base/dim/nvec when idle.
- abort  in  1  synchronous abort; returns to IDLE next cycle.
- base  in  ADDR_W  first word address.
- dim  in  DIM_W  words per vector.
- nvec  in  NVEC_W  number of vectors.
- cache_address  out  ADDR_W  to cache address2.
- cache_chipselect  out  1  to chipselect2.
- cache_clken  out  1  to clken2; tied 1.
- cache_write  out  1  to write2; tied 0.
- cache_byteenable  out  4  to byteenable2; tied 4'hF.
- cache_readdata  in  DATA_W  from readdata2.
- out_data  out  DATA_W  stream word.
- out_valid  out  1  word present.
- out_ready  in  1  consumer accepts when valid&ready.
- out_sop  out  1  first word of a vector.
- out_eop  out  1  last word of a vector.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after last word accepted.
- err  out  1  one-cycle pulse on rejected start.

## Operation
- FSM: IDLE -> RUN on start (legal); RUN -> DRAIN when last read issued; DRAIN -> IDLE when skid buffer empty and no read in flight; done pulses on the DRAIN -> IDLE transition.
- start while busy is ignored (no err).
- start with dim==0 or nvec==0: no reads, done pulses next cycle, busy stays low.
- Read issue rule: issue when occupancy + inflight − pop_this_cycle < 2; cache_chipselect high exactly on issue cycles.
- Address: cache_address = base + running word index, ADDR_W-bit arithmetic.
- Total words = dim × nvec, computed at DIM_W+NVEC_W bits.
- Word and vector counters: word_in_vec 0..dim−1, wraps and increments vec_idx; sop when word_in_vec==0, eop when word_in_vec==dim−1; markers stored alongside data in the buffer.
- Buffer order is FIFO; out_valid = occupancy≠0; out_data/sop/eop from head entry.
- abort: clears FSM, counters, buffer, and inflight; the in-flight return is discarded; no done pulse.
- Reset values: cache_address 0, cache_chipselect 0, out_data 0, out_valid 0, out_sop 0, out_eop 0, busy 0, done 0, err 0.

## Timing
- Read issued at edge N; cache_readdata captured into the buffer at edge N+1.
- First out_valid: 2 cycles after start with out_ready high.
- Sustained throughput: 1 word/cycle while out_ready is held high.
- out_ready low: at most 2 words buffered; issuing stops; resume issue in the cycle pop occurs.
- done: 1 cycle after acceptance of the final eop word.
- busy: rises the cycle after start, falls with done.

## Configuration
- KNN_STREAM_WRAP_EN defined: base + total words may exceed depth; address wraps modulo 2**ADDR_W; err never asserts.
- Undefined: start with base + dim×nvec > 2**ADDR_W is rejected; err pulses one cycle, state stays IDLE.

## Structure
- Shared package knn_acc_pkg: DATA_W/ADDR_W defaults, FSM state enum (IDLE, RUN, DRAIN), stream-entry struct {data, sop, eop}.
- One sub-module: knn_skid_fifo2, a 2-entry FIFO with push/pop/occupancy; the FSM and counters live in the top.

## Test plan
- base=0, dim=4, nvec=2, out_ready=1 → 8 words from addr 0..7; sop on words 0 and 4; eop on words 3 and 7; done 1 cycle after word 7.
- Same run with out_ready toggling 1-0-0-1 → words and markers identical, no drops or duplicates, cache_chipselect never drives >2 outstanding.
- base=508, dim=8, nvec=1: WRAP_EN → addresses 508..511, 0..3; no macro → err pulse, no reads, busy low.
- dim=0 → done next cycle, out_valid never rises.
- abort on the 3rd word with out_ready=0 → out_valid low next cycle, busy low, no done; new start runs cleanly.
- reset_n asserted mid-RUN → all outputs at reset values asynchronously; after release the next start streams from its base.
